// File: rtl/clock_stepper_gen_if.sv
// Control inputs and phase/stepper outputs of clock_stepper_gen.
// The generator is the slave; the control section that drives it is the master.
interface clock_stepper_gen_if #(
  parameter int NUM_STEPS = 6
);
  localparam int SW = $clog2(NUM_STEPS);

  logic          run;
  logic          step_req;
  logic          step_rst;
  logic          clk;
  logic          clk_d;
  logic          clk_e;
  logic          clk_s;
  logic [NUM_STEPS-1:0] step;
  logic [SW-1:0] step_idx;
  logic          cycle_end;
  logic          halted;

  modport master (
    output run, step_req, step_rst,
    input  clk, clk_d, clk_e, clk_s, step, step_idx, cycle_end, halted
  );

  modport slave (
    input  run, step_req, step_rst,
    output clk, clk_d, clk_e, clk_s, step, step_idx, cycle_end, halted
  );
endinterface

// File: rtl/clock_stepper_gen.sv
// Four-phase machine clock generator with integrated one-hot stepper and
// run / halt / single-step control. All outputs are registered.
//
// state | meaning
// IDLE  | halted, q parked at 3, all phase outputs low
// RUN   | executing machine cycles; boundary decision at terminal sys_clk of Q3
module clock_stepper_gen #(
  parameter int PHASE_CYCLES = 2,
  parameter int NUM_STEPS    = 6
) (
  input logic sys_clk,
  input logic rst_n,
  clock_stepper_gen_if.slave bus
);
  localparam int SW = $clog2(NUM_STEPS);
  localparam int PW = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PHASE_CYCLES - 1);
  localparam logic [SW-1:0] IDX_LAST = SW'(NUM_STEPS - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state;
  logic [PW-1:0] pre;
  logic [1:0]    q;
  logic          ss;
  logic          rst_pend;
  logic          pre_tc;
  logic [SW-1:0] idx_adv;

  // {clk, clk_d, clk_e, clk_s} for the quarter being entered
  function automatic logic [3:0] phase_bits(input logic [1:0] qq);
    logic [3:0] r;
    r = 4'b0000;
    case (qq)
      2'd0: r = 4'b1010;
      2'd1: r = 4'b1111;
      2'd2: r = 4'b0110;
      default: r = 4'b0000;
    endcase
    return r;
  endfunction

  assign pre_tc = (pre == PRE_LAST);

  // A step_rst arriving on the advance edge itself still forces index 0
  assign idx_adv = (rst_pend || bus.step_rst) ? '0 :
                   (bus.step_idx == IDX_LAST) ? '0 : bus.step_idx + 1'b1;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      pre           <= '0;
      q             <= 2'd3;
      ss            <= 1'b0;
      rst_pend      <= 1'b0;
      bus.clk       <= 1'b0;
      bus.clk_d     <= 1'b0;
      bus.clk_e     <= 1'b0;
      bus.clk_s     <= 1'b0;
      bus.step      <= NUM_STEPS'(1);
      bus.step_idx  <= '0;
      bus.cycle_end <= 1'b0;
      bus.halted    <= 1'b1;
    end else begin
      bus.cycle_end <= 1'b0;
      if (bus.step_rst) rst_pend <= 1'b1;
      case (state)
        IDLE: begin
          if (bus.run || bus.step_req) begin
            state      <= RUN;
            pre        <= '0;
            q          <= 2'd0;
            ss         <= bus.step_req;
            bus.halted <= 1'b0;
            {bus.clk, bus.clk_d, bus.clk_e, bus.clk_s} <= phase_bits(2'd0);
          end
        end
        RUN: begin
          if (!pre_tc) begin
            pre           <= pre + 1'b1;
            bus.cycle_end <= (q == 2'd3) && ((pre + 1'b1) == PRE_LAST);
          end else begin
            pre <= '0;
            if (q != 2'd3) begin
              q <= q + 2'd1;
              {bus.clk, bus.clk_d, bus.clk_e, bus.clk_s} <= phase_bits(q + 2'd1);
              // Single-sys_clk quarters: Q3 is its own terminal cycle
              bus.cycle_end <= (q == 2'd2) && (PHASE_CYCLES == 1);
            end else begin
              bus.step_idx <= idx_adv;
              bus.step     <= NUM_STEPS'(1) << idx_adv;
              rst_pend     <= 1'b0;
              if (bus.run && !ss) begin
                q <= 2'd0;
                {bus.clk, bus.clk_d, bus.clk_e, bus.clk_s} <= phase_bits(2'd0);
              end else begin
                state      <= IDLE;
                ss         <= 1'b0;
                bus.halted <= 1'b1;
                {bus.clk, bus.clk_d, bus.clk_e, bus.clk_s} <= 4'b0000;
              end
            end
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_clock_stepper_gen.sv
// Bench for clock_stepper_gen: PHASE_CYCLES=2 and =1 instances share stimulus,
// each checked every cycle against a cycle-position model.
module tb_clock_stepper_gen;
  localparam int NS = 6;

  logic sys_clk = 1'b0;
  logic rst_n   = 1'b1;
  logic run      = 1'b0;
  logic step_req = 1'b0;
  logic step_rst = 1'b0;
  logic chk_en   = 1'b0;
  int   errors   = 0;
  int   checks   = 0;

  always #5 sys_clk = ~sys_clk;

  clock_stepper_gen_if #(.NUM_STEPS(NS)) b2 ();
  clock_stepper_gen_if #(.NUM_STEPS(NS)) b1 ();

  assign b2.run = run;  assign b2.step_req = step_req;  assign b2.step_rst = step_rst;
  assign b1.run = run;  assign b1.step_req = step_req;  assign b1.step_rst = step_rst;

  clock_stepper_gen #(.PHASE_CYCLES(2), .NUM_STEPS(NS)) dut2 (
    .sys_clk(sys_clk), .rst_n(rst_n), .bus(b2));
  clock_stepper_gen #(.PHASE_CYCLES(1), .NUM_STEPS(NS)) dut1 (
    .sys_clk(sys_clk), .rst_n(rst_n), .bus(b1));

  // Model: whether a cycle is executing, and how many sys_clk into it we are
  typedef struct packed {
    logic running;
    int   t;
    int   idx;
    logic pend;
    logic ss;
  } mdl_t;

  mdl_t m2, m1;

  function automatic mdl_t mdl_next(mdl_t m, int pc, logic r, logic rq, logic sr);
    mdl_t n;
    n = m;
    n.pend = m.pend | sr;
    if (!m.running) begin
      if (r || rq) begin
        n.running = 1'b1;
        n.t = 0;
        n.ss = rq;
      end
    end else if (m.t == 4 * pc - 1) begin
      n.idx  = n.pend ? 0 : (m.idx + 1) % NS;
      n.pend = 1'b0;
      if (r && !m.ss) n.t = 0;
      else begin
        n.running = 1'b0;
        n.ss = 1'b0;
      end
    end else begin
      n.t = m.t + 1;
    end
    return n;
  endfunction

  function automatic logic [14:0] mdl_out(mdl_t m, int pc);
    int   qtr;
    logic c, d;
    qtr = m.t / pc;
    c = m.running && (qtr < 2);
    d = m.running && (qtr == 1 || qtr == 2);
    return {c, d, c | d, c & d, m.running && (m.t == 4 * pc - 1), !m.running,
            6'(1 << m.idx), 3'(m.idx)};
  endfunction

  always @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      m2 <= '0;
      m1 <= '0;
    end else begin
      m2 <= mdl_next(m2, 2, run, step_req, step_rst);
      m1 <= mdl_next(m1, 1, run, step_req, step_rst);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge sys_clk) begin
    if (chk_en) begin
      chk("pc2_outputs", 32'({b2.clk, b2.clk_d, b2.clk_e, b2.clk_s, b2.cycle_end, b2.halted,
                              b2.step, b2.step_idx}), 32'(mdl_out(m2, 2)));
      chk("pc1_outputs", 32'({b1.clk, b1.clk_d, b1.clk_e, b1.clk_s, b1.cycle_end, b1.halted,
                              b1.step, b1.step_idx}), 32'(mdl_out(m1, 1)));
    end
  end

  task automatic tick();
    @(negedge sys_clk);
  endtask

  initial begin
    int c_clk, c_e, c_s, c_ce, c_run, first_s, first_ce;

    // Reset with no sys_clk edge
    #1 rst_n = 1'b0;
    #1;
    chk("reset_phase", 32'({b2.clk, b2.clk_d, b2.clk_e, b2.clk_s}), 32'h0);
    chk("reset_step", 32'(b2.step), 32'h01);
    chk("reset_idx", 32'(b2.step_idx), 32'h0);
    chk("reset_halted", 32'(b2.halted), 32'h1);
    tick();
    rst_n = 1'b1;
    chk_en = 1'b1;
    tick();
    tick();

    // Free run
    run = 1'b1;
    c_clk = 0; c_e = 0; c_s = 0; c_ce = 0; first_s = 0; first_ce = 0;
    for (int k = 1; k <= 48; k++) begin
      tick();
      c_clk += int'(b2.clk);
      c_e   += int'(b2.clk_e);
      c_s   += int'(b2.clk_s);
      c_ce  += int'(b2.cycle_end);
      if (b2.clk_s && first_s == 0) first_s = k;
      if (b2.cycle_end && first_ce == 0) first_ce = k;
    end
    chk("run_clk_high", c_clk, 24);
    chk("run_clk_e_high", c_e, 36);
    chk("run_clk_s_high", c_s, 12);
    chk("run_cycle_ends", c_ce, 6);
    chk("run_first_clk_s", first_s, 3);
    chk("run_first_cycle_end", first_ce, 8);
    chk("run_idx_before_wrap", 32'(b2.step_idx), 5);
    tick();
    chk("run_idx_wrap", 32'(b2.step_idx), 0);

    // Halt mid-cycle, during Q1 of step 2
    repeat (18) tick();
    chk("halt_at_idx2", 32'(b2.step_idx), 2);
    chk("halt_in_q1", 32'(b2.clk_s), 1);
    run = 1'b0;
    c_clk = 0; c_e = 0; c_ce = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      c_clk += int'(b2.clk);
      c_e   += int'(b2.clk_e);
      c_ce  += int'(b2.cycle_end);
    end
    chk("halt_cycle_ends", c_ce, 1);
    chk("halt_clk_high", c_clk, 1);
    chk("halt_clk_e_high", c_e, 3);
    chk("halt_idx", 32'(b2.step_idx), 3);
    chk("halt_halted", 32'(b2.halted), 1);

    // Single step, with a second request during the executed cycle
    step_req = 1'b1;
    c_clk = 0; c_ce = 0; c_run = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 1) step_req = 1'b0;
      if (k == 3) step_req = 1'b1;
      if (k == 4) step_req = 1'b0;
      c_clk += int'(b2.clk);
      c_ce  += int'(b2.cycle_end);
      c_run += int'(!b2.halted);
    end
    chk("sstep_clk_high", c_clk, 4);
    chk("sstep_cycle_ends", c_ce, 1);
    chk("sstep_active_cycles", c_run, 8);
    chk("sstep_idx", 32'(b2.step_idx), 4);
    chk("sstep_halted", 32'(b2.halted), 1);

    // step_rst in Q0 of idx 4, then on the Q3 terminal edge
    run = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      tick();
      if (k == 1) step_rst = 1'b1;
      if (k == 2) step_rst = 1'b0;
      if (k == 9) chk("srst_q0_idx", 32'(b2.step_idx), 0);
      if (k == 16) step_rst = 1'b1;
      if (k == 17) begin
        step_rst = 1'b0;
        chk("srst_terminal_idx", 32'(b2.step_idx), 0);
        run = 1'b0;
      end
    end
    repeat (12) tick();

    // Async reset in Q1 of the PHASE_CYCLES=1 instance
    run = 1'b1;
    tick();
    tick();
    chk("areset_pre_q1", 32'(b1.clk_s), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("areset_phase", 32'({b1.clk, b1.clk_d, b1.clk_e, b1.clk_s, b1.cycle_end}), 32'h0);
    chk("areset_step", 32'(b1.step), 32'h01);
    chk("areset_halted", 32'(b1.halted), 32'h1);
    tick();
    rst_n = 1'b1;
    c_clk = 0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 1) chk("areset_first_clk", 32'(b1.clk), 1);
      if (k == 3) chk("areset_clk_low_q2", 32'(b1.clk), 0);
      if (k == 5) chk("areset_period4", 32'(b1.clk), 1);
      c_clk += int'(b1.clk);
    end
    chk("areset_clk_high", c_clk, 4);

    // Randomized control traffic
    for (int k = 0; k < 3000; k++) begin
      tick();
      if ($urandom_range(0, 19) == 0) run = ~run;
      step_req = !step_req && ($urandom_range(0, 9) == 0);
      step_rst = !step_rst && ($urandom_range(0, 14) == 0);
      if ($urandom_range(0, 599) == 0) begin
        #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
    end
    tick();
    chk_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
